bram2_arbiter: RTL
==================

BRAM2_ARBITER -- requirements
Module: bram2_arbiter

Interface
REQ-001 SHALL have parameter DP, default 512, BRAM depth in words.
REQ-002 SHALL have parameter DW, default 24, data width in bits.
REQ-003 SHALL have parameter MW, default DW/8, byte-lane mask width.
REQ-004 SHALL have parameter AW, default $clog2(DP), address width.
REQ-005 SHALL have parameter STARVE_MAX, default 8, maximum consecutive wait cycles before port 1 is forced ahead of port 0.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have ports m0_req/m1_req  input  1  request valid (m0 = scan-out, high priority; m1 = host).
REQ-009 SHALL have ports m0_we/m1_we  input  1  1 = write, 0 = read.
REQ-010 SHALL have ports m0_addr/m1_addr  input  AW  word address.
REQ-011 SHALL have ports m0_wdata/m1_wdata  input  DW  write data.
REQ-012 SHALL have ports m0_sel/m1_sel  input  MW  byte-lane enables for writes.
REQ-013 SHALL have ports m0_gnt/m1_gnt  output  1  request accepted this cycle.
REQ-014 SHALL have ports m0_rvalid/m1_rvalid  output  1  read data valid.
REQ-015 SHALL have ports m0_rdata/m1_rdata  output  DW  read data.
REQ-016 SHALL have ports bram_addr/bram_wdata/bram_sel/bram_we  output  AW/DW/MW/1  command to the BRAM.
REQ-017 SHALL have port bram_rdata  input  DW  BRAM read data, valid the cycle after a read command.
REQ-018 SHALL have port conflict_cnt  output  16  saturating count of cycles with both requests asserted.

Function
REQ-019 SHALL accept a transfer on port N in the cycle where mN_req and mN_gnt are both 1; mN_gnt is combinational from the requests and internal state, and at most one grant is high per cycle.
REQ-020 SHALL grant m0 whenever m0_req=1, unless the starvation flag is set.
REQ-021 SHALL grant m1 when m1_req=1 and either m0_req=0 or the starvation flag is set.
REQ-022 SHALL keep a wait counter: increment (saturating at STARVE_MAX) each cycle m1_req=1 and m1_gnt=0, clear on m1 grant or when m1_req=0.
REQ-023 SHALL set the starvation flag combinationally when the wait counter equals STARVE_MAX.
REQ-024 SHALL drive bram_addr/bram_wdata/bram_sel/bram_we combinationally from the granted port in the grant cycle.
REQ-025 SHALL force bram_sel to all-zero on granted reads.
REQ-026 SHALL drive bram_we=0, bram_sel=0, bram_addr=0, bram_wdata=0 when no port is granted.
REQ-027 SHALL record each accepted read in a one-entry response tag (valid bit + port id).
REQ-028 SHALL assert mN_rvalid for exactly one cycle, the cycle after the accepted read, with mN_rdata=bram_rdata.
REQ-029 SHALL drive mN_rdata to zero whenever mN_rvalid=0.
REQ-030 SHALL produce no rvalid for writes; write latency is the grant cycle.
REQ-031 SHALL sustain one transfer per cycle, including back-to-back reads with pipelined responses to alternating ports.
REQ-032 SHALL allow a requester to change its address/we between consecutive accepted transfers without a bubble.
REQ-033 SHALL increment conflict_cnt when m0_req and m1_req are both 1, and hold it at 16'hFFFF once saturated.

Reset
REQ-034 SHALL, while rst=1 and independently of clk, clear the wait counter, the response tag, and conflict_cnt.
REQ-035 SHALL hold all mN_gnt, mN_rvalid, mN_rdata and bram_* outputs at 0 while rst=1.
REQ-036 SHALL discard a read outstanding when reset asserts; no rvalid follows reset release for it.

Verification
REQ-037 SHALL cover single read: m1 read addr 0x010, BRAM word 0xA1B2C3 -> m1_gnt=1 in cycle T; m1_rvalid=1 with m1_rdata=0xA1B2C3 in T+1 only.
REQ-038 SHALL cover masked write: m0 write addr 0x1FF, wdata 0x112233, sel=3'b101 -> bram_we=1, bram_sel=3'b101 in grant cycle; a later read returns only lanes 0 and 2 updated.
REQ-039 SHALL cover starvation: m0_req and m1_req held high continuously, STARVE_MAX=8 -> m0 granted for 8 cycles, m1 granted on cycle 9, pattern repeats; conflict_cnt increments every cycle.
REQ-040 SHALL cover pipelined mix: m0 read, then m1 read on consecutive cycles -> m0_rvalid at T+1 and m1_rvalid at T+2, with no cross-delivery.
REQ-041 SHALL cover reset mid-read: rst asserted asynchronously between a read grant and the next edge -> m0_rvalid/m1_rvalid stay 0; conflict_cnt=0.
REQ-042 SHALL cover idle and saturation: no requests -> bram_we=0 and all grants 0; forced 65 536 conflict cycles -> conflict_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/bram2_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : bram2_arbiter_if
// Description : Bus bundle for the two-port BRAM arbiter. Contains the
//               request/grant/response signals of both requesters, the
//               command/read-data signals of the shared BRAM and the
//               conflict counter.
//               Port summary:
//                 m0_* / m1_*  request (req, we, addr, wdata, sel) and
//                              response (gnt, rvalid, rdata) per requester
//                 bram_*       command to the BRAM, and its read data
//                 conflict_cnt saturating count of contended cycles
//               Modports:
//                 slave  - arbiter side (consumes requests, drives BRAM)
//                 master - environment side (requesters plus BRAM model)
// Revision    : 1.0 - initial release
// ============================================================================
interface bram2_arbiter_if #(
    parameter int DW = 24,
    parameter int MW = DW / 8,
    parameter int AW = 9
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [MW-1:0] m0_sel;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [MW-1:0] m1_sel;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [MW-1:0] bram_sel;
    logic          bram_we;
    logic [DW-1:0] bram_rdata;

    logic [15:0]   conflict_cnt;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_sel,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_sel,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output bram_addr, bram_wdata, bram_sel, bram_we,
        input  bram_rdata,
        output conflict_cnt
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_sel,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_sel,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  bram_addr, bram_wdata, bram_sel, bram_we,
        output bram_rdata,
        input  conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bram2_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram2_arbiter
// Description : Two-requester arbiter in front of a single-port BRAM.
//               m0 (scan-out) has fixed priority over m1 (host), except
//               when m1 has waited STARVE_MAX consecutive cycles, in which
//               case m1 is forced ahead for one transfer. One transfer per
//               cycle; read data returns one cycle after the grant and is
//               steered back to the requester that issued the read.
//               Ports:
//                 clk  - clock, rising edge
//                 rst  - asynchronous active-high reset
//                 bus  - bram2_arbiter_if.slave (requests, grants, read
//                        responses, BRAM command, conflict counter)
// Revision    : 1.0 - initial release
// ============================================================================
module bram2_arbiter #(
    parameter int DP         = 512,
    parameter int DW         = 24,
    parameter int MW         = DW / 8,
    parameter int AW         = $clog2(DP),
    parameter int STARVE_MAX = 8
) (
    input  wire logic      clk,
    input  wire logic      rst,
    bram2_arbiter_if.slave bus
);
    localparam int               c_WCW        = $clog2(STARVE_MAX + 1);
    localparam logic [c_WCW-1:0] c_STARVE_MAX = c_WCW'(STARVE_MAX);
    localparam logic [15:0]      c_CNT_MAX    = 16'hFFFF;

    logic [c_WCW-1:0] r_wait_cnt;
    logic             r_tag_vld;
    logic             r_tag_port;      // 0 = m0, 1 = m1
    logic [15:0]      r_conflict_cnt;

    logic             w_starve;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_rd_accept;
    logic [AW-1:0]    w_bram_addr;
    logic [DW-1:0]    w_bram_wdata;
    logic [MW-1:0]    w_bram_sel;
    logic             w_bram_we;

    // ------------------------------------------------------------------
    // Grant decision. Starvation only overrides m0 when m1 is actually
    // requesting, so a starved-then-withdrawn m1 never stalls m0.
    // Grants are gated by rst so nothing is issued while in reset.
    // ------------------------------------------------------------------
    assign w_starve = (r_wait_cnt == c_STARVE_MAX);
    assign w_gnt1   = !rst && bus.m1_req && (!bus.m0_req || w_starve);
    assign w_gnt0   = !rst && bus.m0_req && !w_gnt1;

    assign bus.m0_gnt = w_gnt0;
    assign bus.m1_gnt = w_gnt1;

    // ------------------------------------------------------------------
    // BRAM command mux: pass-through of the granted port, all-zero idle.
    // Byte lanes are suppressed on reads so the BRAM never sees a
    // stray lane enable alongside we=0.
    // ------------------------------------------------------------------
    always_comb begin
        w_bram_addr  = '0;
        w_bram_wdata = '0;
        w_bram_sel   = '0;
        w_bram_we    = 1'b0;
        if (w_gnt0) begin
            w_bram_addr  = bus.m0_addr;
            w_bram_wdata = bus.m0_wdata;
            w_bram_sel   = bus.m0_we ? bus.m0_sel : '0;
            w_bram_we    = bus.m0_we;
        end else if (w_gnt1) begin
            w_bram_addr  = bus.m1_addr;
            w_bram_wdata = bus.m1_wdata;
            w_bram_sel   = bus.m1_we ? bus.m1_sel : '0;
            w_bram_we    = bus.m1_we;
        end
    end

    assign bus.bram_addr  = w_bram_addr;
    assign bus.bram_wdata = w_bram_wdata;
    assign bus.bram_sel   = w_bram_sel;
    assign bus.bram_we    = w_bram_we;

    // ------------------------------------------------------------------
    // Wait counter for m1: counts consecutive refused cycles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (!bus.m1_req || w_gnt1) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != c_STARVE_MAX) begin
            r_wait_cnt <= r_wait_cnt + c_WCW'(1);
        end
    end

    // ------------------------------------------------------------------
    // One-entry response tag. BRAM latency is exactly one cycle and at
    // most one read is accepted per cycle, so a single entry suffices
    // even for back-to-back reads from alternating ports.
    // ------------------------------------------------------------------
    assign w_rd_accept = (w_gnt0 && !bus.m0_we) || (w_gnt1 && !bus.m1_we);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld  <= 1'b0;
            r_tag_port <= 1'b0;
        end else begin
            r_tag_vld  <= w_rd_accept;
            r_tag_port <= w_gnt1;
        end
    end

    assign bus.m0_rvalid = r_tag_vld && !r_tag_port;
    assign bus.m1_rvalid = r_tag_vld &&  r_tag_port;
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.bram_rdata : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.bram_rdata : '0;

    // ------------------------------------------------------------------
    // Saturating count of cycles where both requesters contend.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (bus.m0_req && bus.m1_req && (r_conflict_cnt != c_CNT_MAX)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign bus.conflict_cnt = r_conflict_cnt;
endmodule
`default_nettype wire
